vram_write_arbiter: RTL
=======================

# vram_write_arbiter

Shares the single write port of the 600-word text/colour VRAM between two requesters: Avalon-MM CPU writes and a hardware rectangle-fill engine. The fill engine writes one 32-bit pattern into a rectangle of VRAM words. The block sits between the Avalon slave decode and the VRAM write port; the VGA read port is untouched. The CPU has priority, with a starvation guard so a pending fill always makes progress.

## Interface
- ADDR_W, 12, VRAM word address width
- DATA_W, 32, VRAM word width
- ROW_WORDS, 20, words per text row (address = row*ROW_WORDS + col)
- NUM_ROWS, 30, text rows
- STARVE_MAX, 4, consecutive CPU grants tolerated while a fill is pending

- CLK  in  1  system clock (50 MHz)
- RESET_N  in  1  asynchronous active-low reset
- cpu_wr  in  1  CPU write request, held until accepted
- cpu_addr  in  ADDR_W  CPU word address
- cpu_data  in  DATA_W  CPU write data
- cpu_be  in  4  CPU byte enables
- cpu_wait  out  1  waitrequest to the CPU; combinational
- fill_start  in  1  one-cycle fill command strobe
- fill_x0, fill_y0, fill_w, fill_h  in  5 each  rectangle in word/row units
- fill_data  in  DATA_W  fill pattern, latched on fill_start
- fill_abort  in  1  present only with VRAM_ARB_ABORT_EN
- fill_busy  out  1  a fill is in progress
- fill_done  out  1  one-cycle pulse when a fill completes or is aborted
- fill_err  out  1  one-cycle pulse when a command is rejected
- ram_wren  out  1  VRAM write enable
- ram_addr  out  ADDR_W  VRAM write address
- ram_data  out  DATA_W  VRAM write data
- ram_be  out  4  VRAM byte enables (4'b1111 for fill writes)

## Operation
- **States:** IDLE, FILL.
- **Reset values:** all outputs 0; state is IDLE; starvation counter is 0.
- **IDLE:**
  - fill_start is validated.
  - The command is rejected if w==0, h==0, x0+w>ROW_WORDS, or y0+h>NUM_ROWS; sums are computed 6-bit to avoid wrap.
  - On reject: fill_err pulses and the state stays IDLE.
  - On accept: latch fill_data, x0, w, and h; set cur_x=x0, cur_y=y0, and row_base=y0*ROW_WORDS; go to FILL.
- **FILL:**
  - Each cycle arbitrates one write.
  - Fill address is row_base+cur_x.
  - After each fill grant, cur_x increments. When cur_x==x0+w-1, cur_x returns to x0, cur_y increments, and row_base adds ROW_WORDS. There is no multiplier in the loop.
  - After the last word (cur_y==y0+h-1 and cur_x==x0+w-1) is granted, go to IDLE and pulse fill_done.
- **Arbitration:**
  - A CPU request with cpu_wait low is always granted; the fill slot is lost that cycle.
  - The starvation counter increments on each CPU grant in FILL and clears on each fill grant.
  - When the counter reaches STARVE_MAX, cpu_wait is asserted, the fill is granted, and the counter clears.
  - In IDLE, cpu_wait=0 and the counter is held at 0.
- **fill_start while busy:** ignored; no fill_err.
- **Simultaneous fill_start and cpu_wr in IDLE:** the CPU write is granted; the fill command is accepted in the same cycle.
- **Reset mid-fill:** returns to IDLE immediately; no fill_done pulse; any VRAM words already written stay written.

## Timing
- All ram_* outputs are registered: a grant decided in cycle n drives ram_* in cycle n+1, for one cycle.
- fill_start in cycle 0 → fill_busy=1 from cycle 1 → first fill write on the RAM port in cycle 2 (no CPU traffic).
- An uncontended w×h fill occupies the RAM port in cycles 2..w*h+1.
- fill_done and fill_busy=0 occur in cycle w*h+1.
- fill_err is high in cycle 1 for a rejected command.
- cpu_wait depends only on state and the counter, with no combinational path from cpu_wr. The CPU sees at most 1 wait cycle per STARVE_MAX+1 slots.

## Configuration
- **VRAM_ARB_ABORT_EN defined:** fill_abort exists. When high in FILL, no further fill grants are made; the state goes to IDLE next cycle with a fill_done pulse. Any fill write already granted still appears on the RAM port.
- **Not defined:** the port is absent, and fills always run to completion.

## Test plan
- **Uncontended fill:** x0=2, y0=3, w=3, h=2, data=32'hA5A5_0F0F → writes to addresses 62,63,64,82,83,84 in cycles 2–7; fill_done in cycle 7.
- **Reject:** x0=18, w=3 → fill_err pulse in cycle 1; no ram_wren; fill_busy stays 0.
- **Contention:** fill w=20, h=1 with cpu_wr held continuously → pattern of 4 CPU grants, then cpu_wait=1 for 1 cycle and 1 fill grant. All 20 fill words are written. No CPU write is lost or duplicated.
- **fill_start while busy:** a second command during FILL → ignored; first fill completes unchanged; no fill_err.
- **Async reset mid-fill:** assert RESET_N=0 at word 5 of 10 → all outputs 0 at once; no fill_done; next fill works normally.
- **Abort (VRAM_ARB_ABORT_EN):** fill_abort in cycle 4 of w=10, h=1 → 3 fill writes on the RAM port (cycles 2–4); fill_done in cycle 5.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// ---------------------------------------------------------------------------
// vram_write_arbiter
//
// Shares the single write port of the 600-word text/colour VRAM between
// Avalon-MM CPU writes and a rectangle-fill engine. The CPU has priority.
// A starvation counter forces one fill slot after STARVE_MAX consecutive CPU
// grants, so a pending fill always makes progress. All ram_* outputs are
// registered: a grant decided in cycle n appears on the RAM port in n+1.
//
// Optional feature macro: VRAM_ARB_ABORT_EN. When it is defined, the
// fill_abort input exists and stops a running fill.
//
// Ports
//   CLK, RESET_N      clock, asynchronous active-low reset
//   cpu_wr/addr/data/be  CPU write request, held until accepted
//   cpu_wait          waitrequest to the CPU (from state and counter only)
//   fill_start        one-cycle fill command strobe
//   fill_x0/y0/w/h    rectangle in word/row units
//   fill_data         fill pattern, latched on an accepted fill_start
//   fill_abort        stop the running fill (VRAM_ARB_ABORT_EN only)
//   fill_busy         a fill is in progress
//   fill_done         one-cycle pulse on completion or abort
//   fill_err          one-cycle pulse when a command is rejected
//   ram_wren/addr/data/be  registered VRAM write port
// ---------------------------------------------------------------------------
module vram_write_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int ROW_WORDS  = 20,
    parameter int NUM_ROWS   = 30,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic [3:0]        cpu_be,
    output logic              cpu_wait,
    input  logic              fill_start,
    input  logic [4:0]        fill_x0,
    input  logic [4:0]        fill_y0,
    input  logic [4:0]        fill_w,
    input  logic [4:0]        fill_h,
    input  logic [DATA_W-1:0] fill_data,
`ifdef VRAM_ARB_ABORT_EN
    input  logic              fill_abort,
`endif
    output logic              fill_busy,
    output logic              fill_done,
    output logic              fill_err,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic [3:0]        ram_be
);

    localparam int         CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [5:0] ROW_LIM = 6'(ROW_WORDS);
    localparam logic [5:0] ROW_NUM = 6'(NUM_ROWS);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_x0;
    logic [4:0]        r_x_last;
    logic [4:0]        r_y_last;
    logic [4:0]        r_cur_x;
    logic [4:0]        r_cur_y;
    logic [ADDR_W-1:0] r_row_base;
    logic [DATA_W-1:0] r_pat;
    logic              r_done;
    logic              r_err;
    logic              r_ram_wren;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic [3:0]        r_ram_be;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_cpu_grant;
    logic              w_fill_grant;
    logic              w_accept;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_abort;
    logic              w_cpu_wait;
    logic              w_reject;
    logic              w_row_end;
    logic              w_last;
    logic [5:0]        w_x_sum;
    logic [5:0]        w_y_sum;
    logic [ADDR_W-1:0] w_fill_addr;

`ifdef VRAM_ARB_ABORT_EN
    assign w_abort = fill_abort;
`else
    assign w_abort = 1'b0;
`endif

    // 6-bit sums: 5-bit origin plus 5-bit extent can never wrap.
    assign w_x_sum  = {1'b0, fill_x0} + {1'b0, fill_w};
    assign w_y_sum  = {1'b0, fill_y0} + {1'b0, fill_h};
    assign w_reject = (fill_w == 5'd0) || (fill_h == 5'd0) ||
                      (w_x_sum > ROW_LIM) || (w_y_sum > ROW_NUM);

    // Wait is forced only when the CPU has used up its streak during a fill.
    assign w_cpu_wait  = (r_state == FILL) && (r_cnt == CNT_W'(STARVE_MAX));
    assign w_row_end   = (r_cur_x == r_x_last);
    assign w_last      = w_row_end && (r_cur_y == r_y_last);
    assign w_fill_addr = r_row_base + ADDR_W'(r_cur_x);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            // NOTE: state registers take non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path
        // that leaves one unassigned would infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cpu_grant  = 1'b0;
        w_fill_grant = 1'b0;
        w_accept     = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt   = '0;
                w_cpu_grant = cpu_wr;
                if (fill_start) begin
                    if (w_reject) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (cpu_wr && !w_cpu_wait) begin
                    w_cpu_grant = 1'b1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end else if (!w_abort) begin
                    w_fill_grant = 1'b1;
                    w_cnt_nxt    = '0;
                end
                if (w_abort || (w_fill_grant && w_last)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt      <= '0;
            r_x0       <= '0;
            r_x_last   <= '0;
            r_y_last   <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_row_base <= '0;
            r_pat      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ram_wren <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_be   <= '0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_ram_wren <= w_cpu_grant || w_fill_grant;
            if (w_cpu_grant) begin
                r_ram_addr <= cpu_addr;
                r_ram_data <= cpu_data;
                r_ram_be   <= cpu_be;
            end else if (w_fill_grant) begin
                r_ram_addr <= w_fill_addr;
                r_ram_data <= r_pat;
                r_ram_be   <= 4'b1111;
            end
            if (w_accept) begin
                // The only multiply happens once per command; the walk
                // below steps row_base by ROW_WORDS instead.
                r_pat      <= fill_data;
                r_x0       <= fill_x0;
                r_x_last   <= 5'(w_x_sum - 6'd1);
                r_y_last   <= 5'(w_y_sum - 6'd1);
                r_cur_x    <= fill_x0;
                r_cur_y    <= fill_y0;
                r_row_base <= ADDR_W'(fill_y0) * ADDR_W'(ROW_WORDS);
            end else if (w_fill_grant) begin
                if (w_row_end) begin
                    r_cur_x    <= r_x0;
                    r_cur_y    <= r_cur_y + 5'd1;
                    r_row_base <= r_row_base + ADDR_W'(ROW_WORDS);
                end else begin
                    r_cur_x <= r_cur_x + 5'd1;
                end
            end
        end
    end

    assign cpu_wait  = w_cpu_wait;
    assign fill_busy = (r_state == FILL);
    assign fill_done = r_done;
    assign fill_err  = r_err;
    assign ram_wren  = r_ram_wren;
    assign ram_addr  = r_ram_addr;
    assign ram_data  = r_ram_data;
    assign ram_be    = r_ram_be;

endmodule
